// File: rtl/lce_req_arbiter_if.sv
// Bundle of the requester-side and CCE-side signals of the LCE request arbiter.
// master drives requests/ready/complete; slave is the arbiter.
interface lce_req_arbiter_if #(
  parameter int unsigned num_req_p   = 2,
  parameter int unsigned msg_width_p = 128
);
  localparam int unsigned IdW = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [num_req_p*msg_width_p-1:0] req_msg_i;
  logic [num_req_p-1:0]             req_v_i;
  logic [num_req_p-1:0]             req_ready_and_o;
  logic [msg_width_p-1:0]           lce_req_o;
  logic                             lce_req_v_o;
  logic                             lce_req_ready_and_i;
  logic [num_req_p-1:0]             complete_i;
  logic [IdW-1:0]                   grant_id_o;
  logic                             error_o;

  modport master (
    output req_msg_i, req_v_i, lce_req_ready_and_i, complete_i,
    input  req_ready_and_o, lce_req_o, lce_req_v_o, grant_id_o, error_o
  );

  modport slave (
    input  req_msg_i, req_v_i, lce_req_ready_and_i, complete_i,
    output req_ready_and_o, lce_req_o, lce_req_v_o, grant_id_o, error_o
  );
endinterface

// File: rtl/lce_req_arbiter.sv
// Credit-based round-robin arbiter merging LCE requests onto one CCE channel.
// Optional stall/grant statistics are enabled with BP_ME_LCE_REQ_ARB_STATS_EN.
module lce_req_arbiter #(
  parameter int unsigned num_req_p   = 2,
  parameter int unsigned msg_width_p = 128,
  parameter int unsigned credits_p   = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  lce_req_arbiter_if.slave       bus
`ifdef BP_ME_LCE_REQ_ARB_STATS_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [num_req_p*32-1:0] grant_cnt_o
`endif
);
  localparam int unsigned IdW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned CrW = $clog2(credits_p + 1);
  localparam logic [CrW-1:0] CrFull = CrW'(credits_p);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               r_state, w_state_d;
  logic [IdW-1:0]       r_rr_ptr, w_rr_ptr_d;
  logic [IdW-1:0]       r_lock_id, w_lock_id_d;
  logic [CrW-1:0]       r_credit   [num_req_p];
  logic [CrW-1:0]       w_credit_d [num_req_p];
  logic                 r_error, w_error_d;
  logic [num_req_p-1:0] w_eligible;
  logic [IdW-1:0]       w_grant, w_idx;
  logic                 w_found, w_valid, w_hs, w_dec, w_inc;

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      w_eligible[i] = bus.req_v_i[i] && (r_credit[i] != '0);
    end
  end

  // Grant selection: locked grantee, else first eligible upward from r_rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_grant = r_rr_ptr;
    w_idx   = '0;
    if (r_state == StLocked) begin
      w_grant = r_lock_id;
      w_found = bus.req_v_i[r_lock_id];
    end else begin
      for (int k = 0; k < num_req_p; k++) begin
        w_idx = IdW'((32'(r_rr_ptr) + 32'(k)) % num_req_p);
        if (!w_found && w_eligible[w_idx]) begin
          w_found = 1'b1;
          w_grant = w_idx;
        end
      end
    end
  end

  // Valid and accept are forced low while reset is held
  assign w_valid = w_found && reset_n_i;
  assign w_hs    = w_valid && bus.lce_req_ready_and_i;

  assign bus.lce_req_v_o = w_valid;
  assign bus.lce_req_o   = bus.req_msg_i[32'(w_grant)*msg_width_p +: msg_width_p];
  assign bus.grant_id_o  = w_grant;
  assign bus.error_o     = r_error;

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      bus.req_ready_and_o[i] = w_hs && (w_grant == IdW'(i));
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_rr_ptr_d  = r_rr_ptr;
    w_lock_id_d = r_lock_id;
    w_error_d   = r_error;
    w_dec       = 1'b0;
    w_inc       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_valid && !bus.lce_req_ready_and_i) begin
          w_state_d   = StLocked;
          w_lock_id_d = w_grant;
        end
      end
      StLocked: begin
        if (!bus.req_v_i[r_lock_id]) begin
          w_error_d = 1'b1;
          w_state_d = StIdle;
        end else if (w_hs) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_hs) begin
      w_rr_ptr_d = IdW'((32'(w_grant) + 32'd1) % num_req_p);
    end
    // Simultaneous consume and return cancel out
    for (int i = 0; i < num_req_p; i++) begin
      w_credit_d[i] = r_credit[i];
      w_dec = w_hs && (w_grant == IdW'(i));
      w_inc = bus.complete_i[i];
      if (w_inc && !w_dec) begin
        if (r_credit[i] == CrFull) w_error_d = 1'b1;
        else w_credit_d[i] = r_credit[i] + 1'b1;
      end else if (w_dec && !w_inc) begin
        w_credit_d[i] = r_credit[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_error   <= 1'b0;
      for (int i = 0; i < num_req_p; i++) r_credit[i] <= CrFull;
    end else begin
      r_state   <= w_state_d;
      r_rr_ptr  <= w_rr_ptr_d;
      r_lock_id <= w_lock_id_d;
      r_error   <= w_error_d;
      for (int i = 0; i < num_req_p; i++) r_credit[i] <= w_credit_d[i];
    end
  end

`ifdef BP_ME_LCE_REQ_ARB_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_grant_cnt [num_req_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall_cnt <= '0;
      for (int i = 0; i < num_req_p; i++) r_grant_cnt[i] <= '0;
    end else begin
      if (w_valid && !bus.lce_req_ready_and_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      for (int i = 0; i < num_req_p; i++) begin
        if (w_hs && (w_grant == IdW'(i))) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  always_comb begin
    for (int i = 0; i < num_req_p; i++) grant_cnt_o[i*32 +: 32] = r_grant_cnt[i];
  end
`endif
endmodule

// File: tb/tb_lce_req_arbiter.sv
// Self-checking bench for lce_req_arbiter: vector table with a message scoreboard,
// plus hand sequences for lock stability, drop error and reset while locked.
module tb_lce_req_arbiter;
  localparam int unsigned NumReq = 2;
  localparam int unsigned MsgW   = 16;
  localparam logic [15:0] Msg0   = 16'hA0A0;
  localparam logic [15:0] Msg1   = 16'hB1B1;

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [MsgW-1:0] sb[$];
  logic [MsgW-1:0] exp_msg;

  lce_req_arbiter_if #(.num_req_p(NumReq), .msg_width_p(MsgW)) bus ();

`ifdef BP_ME_LCE_REQ_ARB_STATS_EN
  logic [31:0]          stall_cnt;
  logic [NumReq*32-1:0] grant_cnt;
`endif

  lce_req_arbiter #(.num_req_p(NumReq), .msg_width_p(MsgW), .credits_p(2)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
`ifdef BP_ME_LCE_REQ_ARB_STATS_EN
    ,
    .stall_cnt_o (stall_cnt),
    .grant_cnt_o (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] req_v;
    logic       rdy;
    logic [1:0] cmp;
    logic       exp_v;
    logic       exp_gnt;
    logic [1:0] exp_rdy;
    logic       exp_err;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic rdy, input logic [1:0] cmp);
    bus.req_v_i             = v;
    bus.lce_req_ready_and_i = rdy;
    bus.complete_i          = cmp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 with reset released
  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 2'b00);
    next_cycle();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic sample(input string tag, input logic v, input logic g, input logic [1:0] r,
                        input logic e);
    @(negedge clk);
    check({tag, ".v"},   32'(bus.lce_req_v_o),     32'(v));
    check({tag, ".gnt"}, 32'(bus.grant_id_o),      32'(g));
    check({tag, ".rdy"}, 32'(bus.req_ready_and_o), 32'(r));
    check({tag, ".err"}, 32'(bus.error_o),         32'(e));
  endtask

  initial begin
    vecs[0]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[1]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0};
    vecs[2]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[7]  = '{2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[8]  = '{2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[11] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[12] = '{2'b00, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[13] = '{2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[14] = '{2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[15] = '{2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[16] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[17] = '{2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1};
    vecs[18] = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1};

    bus.req_msg_i = {Msg1, Msg0};
    rst_n = 1'b0;
    drive(2'b11, 1'b1, 2'b00);
    #1;
    check("rst.v",   32'(bus.lce_req_v_o),     32'd0);
    check("rst.rdy", 32'(bus.req_ready_and_o), 32'd0);
    check("rst.gnt", 32'(bus.grant_id_o),      32'd0);
    check("rst.err", 32'(bus.error_o),         32'd0);
    do_reset();

    // Table: alternation, credit exhaustion/return, same-cycle consume+return, saturation error
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req_v, vecs[i].rdy, vecs[i].cmp);
      if (vecs[i].exp_v) sb.push_back(vecs[i].exp_gnt ? Msg1 : Msg0);
      sample($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_gnt, vecs[i].exp_rdy,
             vecs[i].exp_err);
      if (bus.lce_req_v_o) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL vec%0d.sb: got output 0x%0h, required no output", i, bus.lce_req_o);
        end else begin
          exp_msg = sb.pop_front();
          check($sformatf("vec%0d.msg", i), 32'(bus.lce_req_o), 32'(exp_msg));
        end
      end
      next_cycle();
    end
    check("sb.drained", 32'(sb.size()), 32'd0);

    // Lock holds grant 0 against req 1 while CCE stalls; rr_ptr is 1 beforehand
    do_reset();
    drive(2'b01, 1'b1, 2'b00); sample("lk0", 1'b1, 1'b0, 2'b01, 1'b0); next_cycle();
    drive(2'b01, 1'b0, 2'b00); sample("lk1", 1'b1, 1'b0, 2'b00, 1'b0);
    check("lk1.msg", 32'(bus.lce_req_o), 32'(Msg0)); next_cycle();
    for (int c = 2; c < 4; c++) begin
      drive(2'b11, 1'b0, 2'b00); sample($sformatf("lk%0d", c), 1'b1, 1'b0, 2'b00, 1'b0);
      check($sformatf("lk%0d.msg", c), 32'(bus.lce_req_o), 32'(Msg0)); next_cycle();
    end
    drive(2'b11, 1'b1, 2'b00); sample("lk4", 1'b1, 1'b0, 2'b01, 1'b0); next_cycle();
    drive(2'b10, 1'b1, 2'b00); sample("lk5", 1'b1, 1'b1, 2'b10, 1'b0);
    check("lk5.msg", 32'(bus.lce_req_o), 32'(Msg1)); next_cycle();

    // Locked requester drops valid: sticky error until reset
    do_reset();
    drive(2'b01, 1'b0, 2'b00); sample("dr0", 1'b1, 1'b0, 2'b00, 1'b0); next_cycle();
    drive(2'b00, 1'b0, 2'b00); sample("dr1", 1'b0, 1'b0, 2'b00, 1'b0); next_cycle();
    drive(2'b10, 1'b1, 2'b00); sample("dr2", 1'b1, 1'b1, 2'b10, 1'b1); next_cycle();
    drive(2'b00, 1'b1, 2'b00); sample("dr3", 1'b0, 1'b0, 2'b00, 1'b1); next_cycle();
    do_reset();
    drive(2'b00, 1'b1, 2'b00); sample("dr4", 1'b0, 1'b0, 2'b00, 1'b0); next_cycle();

    // Reset while locked: outputs drop with no clock edge, then full credits and rr_ptr 0
    drive(2'b01, 1'b1, 2'b00); sample("rl0", 1'b1, 1'b0, 2'b01, 1'b0); next_cycle();
    drive(2'b01, 1'b0, 2'b00); sample("rl1", 1'b1, 1'b0, 2'b00, 1'b0); next_cycle();
    #1;
    rst_n = 1'b0;
    drive(2'b11, 1'b1, 2'b00);
    #1;
    check("rl.async.v",   32'(bus.lce_req_v_o),     32'd0);
    check("rl.async.rdy", 32'(bus.req_ready_and_o), 32'd0);
    check("rl.async.gnt", 32'(bus.grant_id_o),      32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(2'b11, 1'b1, 2'b00); sample("rl2", 1'b1, 1'b0, 2'b01, 1'b0); next_cycle();
    drive(2'b01, 1'b1, 2'b00); sample("rl3", 1'b1, 1'b0, 2'b01, 1'b0); next_cycle();
    drive(2'b01, 1'b1, 2'b00); sample("rl4", 1'b0, 1'b1, 2'b00, 1'b0); next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
